// File: rtl/instruction_fetch_pkg.sv
// Shared types and sizing for the instruction fetch stage and its response FIFO.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int unsigned ADDR_W_DEFAULT  = 16;
  localparam int unsigned INSTR_W_DEFAULT = 64;
  localparam int unsigned FETCH_DEPTH     = 2;
  localparam int unsigned CNT_W           = $clog2(FETCH_DEPTH + 1);
  localparam int unsigned PTR_W           = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FETCH_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small response FIFO between instruction memory and the instruction register.
// Flush wins over push/pop; the head reads as zero while empty.
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned Width = INSTR_W_DEFAULT + ADDR_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [Width-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  logic [FETCH_DEPTH-1:0][Width-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]                  count_q, count_d;
  logic                              do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != '0);
    // A push into a full FIFO only succeeds when the head leaves the same cycle.
    do_push  = push_i && ((count_q != CNT_W'(FETCH_DEPTH)) || do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    valid_o = (count_q != '0);
    rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    count_o = count_q;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, in-order memory requests under a 2-credit limit, response buffering
// and redirect with discard of responses still in flight.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned         INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc
);

  fetch_state_t                     state_q, state_d;
  logic [ADDR_W-1:0]                pc_q, pc_d;
  logic [CNT_W-1:0]                 outst_q, outst_d;
  logic [CNT_W-1:0]                 discard_q, discard_d;
  logic [FETCH_DEPTH-1:0][ADDR_W-1:0] rq_q, rq_d;
  logic [PTR_W-1:0]                 rq_rd_q, rq_rd_d;
  logic [PTR_W-1:0]                 rq_wr;

  logic                      resp, pop, issue;
  logic [CNT_W:0]            inflight;
  logic                      fifo_push, fifo_pop, fifo_flush, fifo_valid;
  logic [CNT_W-1:0]          fifo_count;
  logic [INSTR_W+ADDR_W-1:0] fifo_wdata, fifo_rdata;

  always_comb begin
    resp = mem_rvalid && (outst_q != '0);
    pop  = fifo_valid && instr_ready;
    // Slots already claimed; the entry leaving this cycle frees one, giving 1 instr/cycle.
    inflight = {1'b0, outst_q} + {1'b0, fifo_count} - (CNT_W + 1)'(pop);
    issue    = (state_q == RUN) && !redirect_valid && (inflight < (CNT_W + 1)'(FETCH_DEPTH));
    // Issue only happens with at most one request outstanding, so the slot after head is free.
    rq_wr      = (outst_q == '0) ? rq_rd_q : ptr_inc(rq_rd_q);
    fifo_push  = resp && (state_q == RUN) && !redirect_valid;
    fifo_pop   = pop && !redirect_valid;
    fifo_flush = redirect_valid;
    fifo_wdata = {mem_rdata, rq_q[rq_rd_q]};
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    rq_d      = rq_q;
    rq_rd_d   = rq_rd_q;
    outst_d   = outst_q + CNT_W'(issue) - CNT_W'(resp);
    if (issue) begin
      rq_d[rq_wr] = pc_q;
      pc_d        = pc_q + ADDR_W'(1);
    end
    if (resp) begin
      rq_rd_d = ptr_inc(rq_rd_q);
    end
    case (state_q)
      BOOT: begin
        state_d = RUN;
        if (redirect_valid) pc_d = redirect_pc;
      end
      RUN, FLUSH: begin
        if (redirect_valid) begin
          // Everything still in flight after this edge belongs to the old path.
          pc_d      = redirect_pc;
          discard_d = outst_d;
          state_d   = (outst_d != '0) ? FLUSH : RUN;
        end else if ((state_q == FLUSH) && resp) begin
          discard_d = discard_q - CNT_W'(1);
          if (discard_d == '0) state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      rq_q      <= '0;
      rq_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      rq_q      <= rq_d;
      rq_rd_q   <= rq_rd_d;
    end
  end

  fetch_fifo #(
    .Width(INSTR_W + ADDR_W)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (fifo_push),
    .wdata_i(fifo_wdata),
    .pop_i  (fifo_pop),
    .flush_i(fifo_flush),
    .valid_o(fifo_valid),
    .rdata_o(fifo_rdata),
    .count_o(fifo_count)
  );

  always_comb begin
    mem_req     = issue;
    mem_addr    = pc_q;
    instr_valid = fifo_valid;
    {instr_out, instr_pc} = fifo_rdata;
  end

  rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      !(mem_rvalid && (outst_q == '0)))
    else $error("instruction_fetch: mem_rvalid with no outstanding request");

endmodule
